// File: rtl/loader_pkg.sv
// Shared definitions for the instruction memory loader: byte/word geometry and FSM states.
package loader_pkg;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_W         = BYTE_W * BYTES_PER_WORD;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
        CHK,
        DONE
    } state_t;
endpackage

// File: rtl/word_assembler.sv
// Packs incoming bytes big-endian into a 32-bit word; word_ready flags the byte that completes a word.
module word_assembler
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_ready
);
    localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0] byte_cnt;

    assign word_ready = byte_valid && (byte_cnt == CNT_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (clr) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (byte_valid) begin
            word     <= {word[WORD_W-BYTE_W-1:0], byte_in};
            byte_cnt <= byte_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/instr_mem_loader.sv
// Loads a UART byte stream (count byte + big-endian words) into instruction RAM while holding the core.
// Optional trailing XOR checksum byte is enabled by defining CHECKSUM_EN.
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  core_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  err
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    state_t            state, state_nx;
    logic [7:0]        n_words, word_cnt;
    logic [WORD_W-1:0] word;
    logic              word_ready, arm, capture, last_word, in_range;

    assign arm       = start && (state == IDLE || state == DONE);
    assign last_word = (word_cnt == n_words - 8'd1);
    assign in_range  = (32'(word_cnt) < DEPTH);
    // A byte arriving during WRITE belongs to the next word unless this was the last one.
    assign capture   = rx_valid && (state == DATA || (state == WRITE && !last_word));

    word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clr        (arm),
        .byte_valid (capture),
        .byte_in    (rx_data),
        .word       (word),
        .word_ready (word_ready)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = LEN;
            LEN: begin
                if (rx_valid) begin
                    if (rx_data != 8'd0) state_nx = DATA;
`ifdef CHECKSUM_EN
                    else                 state_nx = CHK;
`else
                    else                 state_nx = DONE;
`endif
                end
            end
            DATA:  if (word_ready) state_nx = WRITE;
            WRITE: begin
                if (!last_word)    state_nx = DATA;
`ifdef CHECKSUM_EN
                else if (rx_valid) state_nx = DONE;
                else               state_nx = CHK;
`else
                else               state_nx = DONE;
`endif
            end
`ifdef CHECKSUM_EN
            CHK:   if (rx_valid) state_nx = DONE;
`endif
            DONE:  if (start) state_nx = LEN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_words  <= '0;
            word_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (arm) begin
                word_cnt <= '0;
                overflow <= 1'b0;
            end
            if (state == LEN && rx_valid) begin
                n_words  <= rx_data;
                overflow <= (32'(rx_data) > DEPTH);
            end
            if (state == WRITE) word_cnt <= word_cnt + 8'd1;
        end
    end

`ifdef CHECKSUM_EN
    logic [7:0] sum;

    // The checksum byte may arrive in the final WRITE cycle as well as in CHK.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum <= '0;
            err <= 1'b0;
        end else if (arm) begin
            sum <= '0;
            err <= 1'b0;
        end else begin
            if (capture) sum <= sum ^ rx_data;
            if (rx_valid && (state == CHK || (state == WRITE && last_word)))
                err <= (rx_data != sum);
        end
    end
`else
    assign err = 1'b0;
`endif

    assign mem_we    = (state == WRITE) && in_range;
    assign mem_addr  = word_cnt[ADDR_WIDTH-1:0];
    assign mem_wdata = word;
    assign busy      = (state == LEN) || (state == DATA) || (state == WRITE) || (state == CHK);
    assign core_hold = busy;
    assign done      = (state == DONE);
endmodule
